// File: rtl/reduction_frame_acc.sv
// reduction_frame_acc
// Streams WIDTH-bit words of a frame over valid/ready and folds AND/OR/XOR
// reductions across every bit of the frame. It also counts beats, saturating
// at 2**CNT_W-1. After the last beat, one registered result is held on a
// valid/ready output until downstream takes it. The input stalls while the
// result waits, which costs one bubble cycle per frame.
module reduction_frame_acc #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_and,
    output logic             m_or,
    output logic             m_xor,
    output logic             m_nand,
    output logic             m_nor,
    output logic             m_xnor,
    output logic [CNT_W-1:0] m_count,
    output logic             m_sat
);

    typedef enum logic {
        COLLECT = 1'b0,
        DRAIN   = 1'b1
    } state_e;

    state_e             state_q, state_d;

    logic               acc_and_q, acc_and_d;
    logic               acc_or_q, acc_or_d;
    logic               acc_xor_q, acc_xor_d;
    logic               acc_sat_q, acc_sat_d;
    logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;

    logic               res_and_q, res_and_d;
    logic               res_or_q, res_or_d;
    logic               res_xor_q, res_xor_d;
    logic               res_sat_q, res_sat_d;
    logic [CNT_W-1:0]   res_cnt_q, res_cnt_d;
    logic               valid_q, valid_d;

    logic               beat;
    logic               cnt_full;
    logic               fold_and;
    logic               fold_or;
    logic               fold_xor;
    logic               fold_sat;
    logic [CNT_W-1:0]   fold_cnt;

    // Accumulator state with the current beat folded in.
    always_comb begin
        beat     = s_valid && (state_q == COLLECT);
        cnt_full = (acc_cnt_q == {CNT_W{1'b1}});
        fold_and = acc_and_q & (&s_data);
        fold_or  = acc_or_q | (|s_data);
        fold_xor = acc_xor_q ^ (^s_data);
        fold_cnt = cnt_full ? acc_cnt_q : acc_cnt_q + CNT_W'(1);
        fold_sat = acc_sat_q | cnt_full;
    end

    // Next-state logic: collect beats, load the result on the last beat, then wait for the drain handshake.
    always_comb begin
        state_d   = state_q;
        acc_and_d = acc_and_q;
        acc_or_d  = acc_or_q;
        acc_xor_d = acc_xor_q;
        acc_sat_d = acc_sat_q;
        acc_cnt_d = acc_cnt_q;
        res_and_d = res_and_q;
        res_or_d  = res_or_q;
        res_xor_d = res_xor_q;
        res_sat_d = res_sat_q;
        res_cnt_d = res_cnt_q;
        valid_d   = valid_q;
        case (state_q)
            COLLECT: begin
                if (beat) begin
                    if (s_last) begin
                        // Publish the folded frame and return the accumulators to identity.
                        res_and_d = fold_and;
                        res_or_d  = fold_or;
                        res_xor_d = fold_xor;
                        res_sat_d = fold_sat;
                        res_cnt_d = fold_cnt;
                        valid_d   = 1'b1;
                        acc_and_d = 1'b1;
                        acc_or_d  = 1'b0;
                        acc_xor_d = 1'b0;
                        acc_sat_d = 1'b0;
                        acc_cnt_d = '0;
                        state_d   = DRAIN;
                    end else begin
                        acc_and_d = fold_and;
                        acc_or_d  = fold_or;
                        acc_xor_d = fold_xor;
                        acc_sat_d = fold_sat;
                        acc_cnt_d = fold_cnt;
                    end
                end
            end
            DRAIN: begin
                if (valid_q && m_ready) begin
                    valid_d = 1'b0;
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // Running accumulators; reset drops any partially collected frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_and_q <= 1'b1;
            acc_or_q  <= 1'b0;
            acc_xor_q <= 1'b0;
            acc_sat_q <= 1'b0;
            acc_cnt_q <= '0;
        end else begin
            acc_and_q <= acc_and_d;
            acc_or_q  <= acc_or_d;
            acc_xor_q <= acc_xor_d;
            acc_sat_q <= acc_sat_d;
            acc_cnt_q <= acc_cnt_d;
        end
    end

    // Result registers and output valid; results change only on the last-beat load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_and_q <= 1'b0;
            res_or_q  <= 1'b0;
            res_xor_q <= 1'b0;
            res_sat_q <= 1'b0;
            res_cnt_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            res_and_q <= res_and_d;
            res_or_q  <= res_or_d;
            res_xor_q <= res_xor_d;
            res_sat_q <= res_sat_d;
            res_cnt_q <= res_cnt_d;
            valid_q   <= valid_d;
        end
    end

    assign s_ready = (state_q == COLLECT);
    assign m_valid = valid_q;
    assign m_and   = res_and_q;
    assign m_or    = res_or_q;
    assign m_xor   = res_xor_q;
    assign m_nand  = ~res_and_q;
    assign m_nor   = ~res_or_q;
    assign m_xnor  = ~res_xor_q;
    assign m_count = res_cnt_q;
    assign m_sat   = res_sat_q;

endmodule

// File: tb/tb_reduction_frame_acc.sv
// Testbench for reduction_frame_acc. It runs two instances in lockstep on shared
// inputs: one with the default counter width and one with CNT_W=2, so that
// saturation is reachable. Expected results come from a frame-level model that
// reduces every bit of the frame.
module tb_reduction_frame_acc;

    logic       clk;
    logic       rst_n;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_last;
    logic       m_ready;

    logic       s_ready_a, m_valid_a, m_and_a, m_or_a, m_xor_a, m_nand_a, m_nor_a, m_xnor_a, m_sat_a;
    logic [7:0] m_count_a;
    logic       s_ready_b, m_valid_b, m_and_b, m_or_b, m_xor_b, m_nand_b, m_nor_b, m_xnor_b, m_sat_b;
    logic [1:0] m_count_b;

    logic [14:0] got_a;
    logic [8:0]  got_b;
    logic [14:0] exp_a;
    logic [8:0]  exp_b;

    int total;
    int bad;
    logic [7:0] frame_q[$];

    reduction_frame_acc #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_a), .s_data(s_data),
        .s_last(s_last), .m_valid(m_valid_a), .m_ready(m_ready), .m_and(m_and_a), .m_or(m_or_a),
        .m_xor(m_xor_a), .m_nand(m_nand_a), .m_nor(m_nor_a), .m_xnor(m_xnor_a),
        .m_count(m_count_a), .m_sat(m_sat_a)
    );

    reduction_frame_acc #(.WIDTH(8), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_b), .s_data(s_data),
        .s_last(s_last), .m_valid(m_valid_b), .m_ready(m_ready), .m_and(m_and_b), .m_or(m_or_b),
        .m_xor(m_xor_b), .m_nand(m_nand_b), .m_nor(m_nor_b), .m_xnor(m_xnor_b),
        .m_count(m_count_b), .m_sat(m_sat_b)
    );

    assign got_a = {m_and_a, m_or_a, m_xor_a, m_nand_a, m_nor_a, m_xnor_a, m_sat_a, m_count_a};
    assign got_b = {m_and_b, m_or_b, m_xor_b, m_nand_b, m_nor_b, m_xnor_b, m_sat_b, m_count_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Present one beat and hold it until the block accepts it.
    task automatic send_beat(input logic [7:0] d, input logic last);
        int guard;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        guard   = 0;
        while (s_ready_a !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            total++;
            bad++;
            $display("FAIL beat_timeout: s_ready=%b after %0d cycles, required 1", s_ready_a, guard);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Send frame_q with optional idle gaps carrying junk data, then check latency and the result.
    task automatic send_frame(input int gap_max);
        int   n;
        logic e_and, e_or, e_xor, sat_a, sat_b;
        logic [7:0] cnt_a;
        logic [1:0] cnt_b;
        n     = frame_q.size();
        e_and = 1'b1;
        e_or  = 1'b0;
        e_xor = 1'b0;
        foreach (frame_q[i]) begin
            for (int b = 0; b < 8; b++) begin
                e_and = e_and & frame_q[i][b];
                e_or  = e_or | frame_q[i][b];
                e_xor = e_xor ^ frame_q[i][b];
            end
        end
        sat_a = (n > 255);
        cnt_a = sat_a ? 8'd255 : 8'(n);
        sat_b = (n > 3);
        cnt_b = sat_b ? 2'd3 : 2'(n);
        exp_a = {e_and, e_or, e_xor, ~e_and, ~e_or, ~e_xor, sat_a, cnt_a};
        exp_b = {e_and, e_or, e_xor, ~e_and, ~e_or, ~e_xor, sat_b, cnt_b};
        for (int i = 0; i < n; i++) begin
            if (gap_max > 0) begin
                repeat ($urandom_range(0, gap_max)) begin
                    @(negedge clk);
                    s_valid = 1'b0;
                    s_data  = 8'($urandom);
                    s_last  = 1'($urandom);
                end
            end
            send_beat(frame_q[i], (i == n - 1));
        end
        total++;
        if (m_valid_a !== 1'b1 || m_valid_b !== 1'b1 || s_ready_a !== 1'b0 || s_ready_b !== 1'b0) begin
            bad++;
            $display("FAIL latency: m_valid=%b/%b s_ready=%b/%b, required m_valid=1/1 s_ready=0/0",
                     m_valid_a, m_valid_b, s_ready_a, s_ready_b);
        end
        total++;
        if (got_a !== exp_a) begin
            bad++;
            $display("FAIL result_w8 (len %0d): got %h, required %h", n, got_a, exp_a);
        end
        total++;
        if (got_b !== exp_b) begin
            bad++;
            $display("FAIL result_w2 (len %0d): got %h, required %h", n, got_b, exp_b);
        end
    endtask

    // Stall for rdy_delay cycles with junk on the input, then complete the output handshake.
    task automatic drain(input int rdy_delay);
        for (int k = 0; k < rdy_delay; k++) begin
            @(negedge clk);
            total++;
            if (s_ready_a !== 1'b0 || m_valid_a !== 1'b1 || got_a !== exp_a || got_b !== exp_b) begin
                bad++;
                $display("FAIL stall_hold: s_ready=%b m_valid=%b res=%h/%h, required 0 1 %h/%h",
                         s_ready_a, m_valid_a, got_a, got_b, exp_a, exp_b);
            end
            s_valid = 1'b1;
            s_last  = 1'b1;
            s_data  = 8'($urandom);
        end
        @(negedge clk);
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        total++;
        if (m_valid_a !== 1'b0 || m_valid_b !== 1'b0 || s_ready_a !== 1'b1 || s_ready_b !== 1'b1) begin
            bad++;
            $display("FAIL handshake: m_valid=%b/%b s_ready=%b/%b, required 0/0 1/1",
                     m_valid_a, m_valid_b, s_ready_a, s_ready_b);
        end
        @(negedge clk);
        total++;
        if (got_a !== exp_a || got_b !== exp_b || m_valid_a !== 1'b0) begin
            bad++;
            $display("FAIL post_hold: res=%h/%h m_valid=%b, required %h/%h 0",
                     got_a, got_b, m_valid_a, exp_a, exp_b);
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
        m_ready = 1'b0;
        #3;
        total++;
        if (m_valid_a !== 1'b0 || got_a !== 15'b000111_0_00000000 || got_b !== 9'b000111_0_00
            || s_ready_a !== 1'b1) begin
            bad++;
            $display("FAIL reset_state: m_valid=%b res=%h/%h s_ready=%b, required 0 %h/%h 1",
                     m_valid_a, got_a, got_b, s_ready_a, 15'b000111_0_00000000, 9'b000111_0_00);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        frame_q = '{8'h00};
        send_frame(0);
        drain(0);
        frame_q = '{8'hFF, 8'hFF};
        send_frame(0);
        drain(1);
        frame_q = '{8'hBB, 8'h33, 8'h01};
        send_frame(2);
        drain(0);
    endtask

    task automatic test_backpressure();
        frame_q = '{8'h5A, 8'hC3};
        send_frame(0);
        drain(3);
        frame_q = '{8'hAA};
        send_frame(0);
        drain(0);
    endtask

    task automatic test_saturation();
        frame_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        send_frame(0);
        drain(0);
        frame_q = '{8'hFF, 8'hFF, 8'hFF};
        send_frame(1);
        drain(0);
        frame_q = '{};
        for (int i = 0; i < 260; i++) frame_q.push_back(8'hFF);
        send_frame(0);
        drain(0);
        frame_q = '{8'h10};
        send_frame(0);
        drain(0);
    endtask

    task automatic test_reset_midframe();
        send_beat(8'h01, 1'b0);
        send_beat(8'h01, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (m_valid_a !== 1'b0 || m_valid_b !== 1'b0 || s_ready_a !== 1'b1 || m_count_a !== 8'd0) begin
            bad++;
            $display("FAIL reset_midframe: m_valid=%b/%b s_ready=%b m_count=%0d, required 0/0 1 0",
                     m_valid_a, m_valid_b, s_ready_a, m_count_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        frame_q = '{8'h01};
        send_frame(0);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (m_valid_a !== 1'b0 || m_valid_b !== 1'b0 || s_ready_a !== 1'b1 || got_a !== 15'b000111_0_00000000) begin
            bad++;
            $display("FAIL reset_drain: m_valid=%b/%b s_ready=%b res=%h, required 0/0 1 %h",
                     m_valid_a, m_valid_b, s_ready_a, got_a, 15'b000111_0_00000000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        frame_q = '{8'h01};
        send_frame(0);
        drain(0);
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 6; f++) begin
            frame_q = '{};
            for (int i = 0; i < f + 1; i++) frame_q.push_back(8'($urandom));
            send_frame(0);
            drain(0);
        end
    endtask

    task automatic test_random();
        int len;
        for (int f = 0; f < 30; f++) begin
            len = $urandom_range(1, 8);
            frame_q = '{};
            for (int i = 0; i < len; i++) begin
                case ($urandom_range(0, 3))
                    0:       frame_q.push_back(8'hFF);
                    1:       frame_q.push_back(8'h00);
                    default: frame_q.push_back(8'($urandom));
                endcase
            end
            send_frame(2);
            drain($urandom_range(0, 3));
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_directed();
        test_backpressure();
        test_saturation();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
